// File: rtl/rr_arbiter_4_onehot_if.sv
// Request/grant bundle between four requesters (master) and the round-robin
// arbiter (slave).
interface rr_arbiter_4_onehot_if;
  logic [3:0] req_lines;
  logic [3:0] grant_lines;
  logic       grant_valid;
  logic [1:0] grant_idx;

  modport master (
    output req_lines,
    input  grant_lines,
    input  grant_valid,
    input  grant_idx
  );

  modport slave (
    input  req_lines,
    output grant_lines,
    output grant_valid,
    output grant_idx
  );
endinterface

// File: rtl/rr_arbiter_4_onehot.sv
// Four-way round-robin arbiter with a registered one-hot grant, binary index and an
// optional hold limit that forces rotation when others are waiting.
module rr_arbiter_4_onehot #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned MAX_HOLD  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  rr_arbiter_4_onehot_if.slave bus
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD) + 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [HoldW-1:0]     hold_q, hold_d;
  logic [NUM_LINES-1:0] grant_q, grant_d;
  logic [1:0]           idx_q, idx_d;
  logic                 valid_q, valid_d;

  logic [NUM_LINES-1:0] req;
  logic [NUM_LINES-1:0] others;
  logic [2:0]           any_win;
  logic [2:0]           oth_win;
  logic                 owner_req;
  logic                 at_limit;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
  function automatic logic [2:0] pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] cand;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      cand = start + 2'(k);
      if (mask[cand]) pick = {1'b1, cand};
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  assign req       = bus.req_lines;
  assign others    = req & ~grant_q;
  assign any_win   = pick(req, ptr_q);
  assign oth_win   = pick(others, ptr_q);
  assign owner_req = |(req & grant_q);
  assign at_limit  = (MAX_HOLD != 0) && (hold_q == HoldLast);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (any_win[2]) begin
          state_d = StGrant;
          grant_d = onehot(any_win[1:0]);
          idx_d   = any_win[1:0];
          valid_d = 1'b1;
          ptr_d   = any_win[1:0] + 2'd1;
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (owner_req) begin
          if (at_limit) begin
            hold_d = '0;
            // Owner excluded from the search so a waiting line gets its turn.
            if (oth_win[2]) begin
              grant_d = onehot(oth_win[1:0]);
              idx_d   = oth_win[1:0];
              ptr_d   = oth_win[1:0] + 2'd1;
            end
          end else if (hold_q != '1) begin
            hold_d = hold_q + 1'b1;
          end
        end else if (oth_win[2]) begin
          grant_d = onehot(oth_win[1:0]);
          idx_d   = oth_win[1:0];
          ptr_d   = oth_win[1:0] + 2'd1;
          hold_d  = '0;
        end else begin
          state_d = StIdle;
          grant_d = '0;
          idx_d   = 2'd0;
          valid_d = 1'b0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        idx_d   = 2'd0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
      grant_q <= '0;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign bus.grant_lines = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_idx   = idx_q;

endmodule
